// File: rtl/oric_kbd_matrix_if.sv
// oric_kbd_matrix_if
//   Bundles the keyboard-side signals of oric_kbd_matrix.
//   ps2_key   : host PS/2 event word {toggle, press, ext, code[7:0]}
//   row_sel   : matrix row being scanned (VIA PB2:0)
//   col_mask  : active-low column select (PSG port A)
//   key_sense : 1 when a selected column in row_sel holds a pressed key
//   nmi_n     : active-low NMI request (Oric reset button on F12)
//   key_act   : one-cycle pulse per accepted matrix update
//   master drives the host/scan side, slave is the keyboard block.
interface oric_kbd_matrix_if;
   logic [10:0] ps2_key;
   logic [2:0]  row_sel;
   logic [7:0]  col_mask;
   logic        key_sense;
   logic        nmi_n;
   logic        key_act;

   modport master (
      output ps2_key,
      output row_sel,
      output col_mask,
      input  key_sense,
      input  nmi_n,
      input  key_act
   );

   modport slave (
      input  ps2_key,
      input  row_sel,
      input  col_mask,
      output key_sense,
      output nmi_n,
      output key_act
   );
endinterface

// File: rtl/oric_kbd_matrix.sv
// oric_kbd_matrix
//   Turns host PS/2 key events into the Oric 8x8 keyboard matrix and answers the
//   VIA row/column scan with the PB3 sense bit. F12 drives the NMI (reset button).
//   Ports:
//     clk_sys  : system clock
//     reset_n  : asynchronous active-low reset
//     io_kbd   : oric_kbd_matrix_if.slave (ps2_key, row_sel, col_mask in;
//                key_sense, nmi_n, key_act out)
//   Pipeline from the toggle edge: cycle 0 event sampled, cycle 1 ROM address,
//   cycle 2 ROM data, cycle 3 matrix write + key_act, cycle 4 key_sense.
module oric_kbd_matrix #(
   parameter int unsigned NMI_STRETCH = 64
) (
   input  logic                clk_sys,
   input  logic                reset_n,
   oric_kbd_matrix_if.slave    io_kbd
);

   localparam int unsigned CntW = (NMI_STRETCH < 1) ? 1 : $clog2(NMI_STRETCH + 1);

   // Stage 0: toggle copy and captured event {press, ext, code}
   logic             r_tog;
   logic             r_evt_vld;
   logic [9:0]       r_evt;
   // Stage 1: ROM address
   logic             r_addr_vld;
   logic [9:0]       r_addr;
   // Stage 2: ROM data
   logic             r_map_vld;
   logic             r_map_nmi;
   logic             r_map_press;
   logic [2:0]       r_map_row;
   logic [2:0]       r_map_col;
   // Matrix and outputs
   logic [7:0][7:0]  r_matrix;
   logic             r_key_act;
   logic             r_key_sense;
   logic             r_nmi_n;
   logic             r_nmi_held;
   logic [CntW-1:0]  r_nmi_cnt;

   logic             w_evt;
   logic             w_hit;
   logic             w_nmi;
   logic [5:0]       w_cell;
   logic             w_held_d;
   logic [CntW-1:0]  w_cnt_d;

   assign w_evt = io_kbd.ps2_key[10] ^ r_tog;

   // Map ROM, indexed by {ext, code}; w_cell is {row, col} in octal.
   always_comb begin
      w_hit  = 1'b1;
      w_nmi  = 1'b0;
      w_cell = 6'o00;
      case (r_addr[8:0])
         9'h029: w_cell = 6'o00;  // Space
         9'h01A: w_cell = 6'o01;  // Z
         9'h022: w_cell = 6'o02;  // X
         9'h021: w_cell = 6'o03;  // C
         9'h02A: w_cell = 6'o04;  // V
         9'h032: w_cell = 6'o05;  // B
         9'h031: w_cell = 6'o06;  // N
         9'h03A: w_cell = 6'o07;  // M
         9'h016: w_cell = 6'o10;  // 1
         9'h01E: w_cell = 6'o11;  // 2
         9'h026: w_cell = 6'o12;  // 3
         9'h025: w_cell = 6'o13;  // 4
         9'h02E: w_cell = 6'o14;  // 5
         9'h036: w_cell = 6'o15;  // 6
         9'h03D: w_cell = 6'o16;  // 7
         9'h03E: w_cell = 6'o17;  // 8
         9'h046: w_cell = 6'o20;  // 9
         9'h045: w_cell = 6'o21;  // 0
         9'h04E: w_cell = 6'o22;  // -
         9'h055: w_cell = 6'o23;  // =
         9'h015: w_cell = 6'o24;  // Q
         9'h01D: w_cell = 6'o25;  // W
         9'h024: w_cell = 6'o26;  // E
         9'h02D: w_cell = 6'o27;  // R
         9'h02C: w_cell = 6'o30;  // T
         9'h035: w_cell = 6'o31;  // Y
         9'h03C: w_cell = 6'o32;  // U
         9'h043: w_cell = 6'o33;  // I
         9'h044: w_cell = 6'o34;  // O
         9'h04D: w_cell = 6'o35;  // P
         9'h054: w_cell = 6'o36;  // [
         9'h05B: w_cell = 6'o37;  // ]
         9'h01B: w_cell = 6'o40;  // S
         9'h023: w_cell = 6'o41;  // D
         9'h02B: w_cell = 6'o42;  // F
         9'h034: w_cell = 6'o43;  // G
         9'h012: w_cell = 6'o44;  // Left shift
         9'h033: w_cell = 6'o45;  // H
         9'h03B: w_cell = 6'o46;  // J
         9'h042: w_cell = 6'o47;  // K
         9'h04B: w_cell = 6'o50;  // L
         9'h04C: w_cell = 6'o51;  // ;
         9'h052: w_cell = 6'o52;  // '
         9'h05D: w_cell = 6'o53;  // backslash
         9'h041: w_cell = 6'o54;  // ,
         9'h049: w_cell = 6'o55;  // .
         9'h04A: w_cell = 6'o56;  // /
         9'h076: w_cell = 6'o57;  // Esc
         9'h014: w_cell = 6'o60;  // Left ctrl
         9'h066: w_cell = 6'o61;  // Backspace -> DEL
         9'h175: w_cell = 6'o62;  // E0 up
         9'h172: w_cell = 6'o63;  // E0 down
         9'h16B: w_cell = 6'o64;  // E0 left
         9'h01C: w_cell = 6'o65;  // A
         9'h174: w_cell = 6'o66;  // E0 right
         9'h00E: w_cell = 6'o67;  // backtick
         9'h005: w_cell = 6'o70;  // F1 -> FUNCT
         9'h114: w_cell = 6'o71;  // E0 right ctrl
         9'h059: w_cell = 6'o74;  // Right shift
         9'h05A: w_cell = 6'o75;  // Return
         9'h15A: w_cell = 6'o75;  // Keypad Enter shares the Return cell
         9'h007: begin            // F12: NMI only, never the matrix
            w_hit = 1'b0;
            w_nmi = 1'b1;
         end
         default: w_hit = 1'b0;
      endcase
   end

   // NMI stays low while F12 is held or the stretch counter is still running.
   always_comb begin
      w_held_d = r_nmi_held;
      w_cnt_d  = r_nmi_cnt;
      if (r_nmi_cnt != '0) begin
         w_cnt_d = r_nmi_cnt - 1'b1;
      end
      if (r_map_nmi) begin
         w_held_d = r_map_press;
         if (r_map_press) begin
            w_cnt_d = CntW'(NMI_STRETCH);
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_tog       <= 1'b0;
         r_evt_vld   <= 1'b0;
         r_evt       <= '0;
         r_addr_vld  <= 1'b0;
         r_addr      <= '0;
         r_map_vld   <= 1'b0;
         r_map_nmi   <= 1'b0;
         r_map_press <= 1'b0;
         r_map_row   <= '0;
         r_map_col   <= '0;
         r_matrix    <= '0;
         r_key_act   <= 1'b0;
         r_key_sense <= 1'b0;
         r_nmi_n     <= 1'b1;
         r_nmi_held  <= 1'b0;
         r_nmi_cnt   <= '0;
      end else begin
         r_tog     <= io_kbd.ps2_key[10];
         r_evt_vld <= w_evt;
         if (w_evt) begin
            r_evt <= io_kbd.ps2_key[9:0];
         end

         r_addr_vld <= r_evt_vld;
         r_addr     <= r_evt;

         r_map_vld   <= r_addr_vld & w_hit;
         r_map_nmi   <= r_addr_vld & w_nmi;
         r_map_press <= r_addr[9];
         r_map_row   <= w_cell[5:3];
         r_map_col   <= w_cell[2:0];

         r_key_act <= r_map_vld;
         if (r_map_vld) begin
            r_matrix[r_map_row][r_map_col] <= r_map_press;
         end

         r_key_sense <= |(r_matrix[io_kbd.row_sel] & ~io_kbd.col_mask);

         r_nmi_held <= w_held_d;
         r_nmi_cnt  <= w_cnt_d;
         r_nmi_n    <= ~(w_held_d | (w_cnt_d != '0));
      end
   end

   assign io_kbd.key_sense = r_key_sense;
   assign io_kbd.nmi_n     = r_nmi_n;
   assign io_kbd.key_act   = r_key_act;

endmodule

// File: tb/tb_oric_kbd_matrix.sv
module tb_oric_kbd_matrix;

   logic clk;
   logic reset_n;
   logic tog;
   int   n_checks;
   int   n_errors;

   oric_kbd_matrix_if kbd ();

   oric_kbd_matrix #(
      .NMI_STRETCH(64)
   ) dut (
      .clk_sys (clk),
      .reset_n (reset_n),
      .io_kbd  (kbd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       press;
      logic       ext;
      logic [7:0] code;
      logic [2:0] row;
      logic [7:0] mask;
      logic       act;
      logic       sense;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Flips the toggle so the DUT sees a new event on the next edge.
   task automatic send_key(input logic press, input logic ext, input logic [7:0] code);
      tog = ~tog;
      kbd.ps2_key = {tog, press, ext, code};
   endtask

   task automatic scan_all_zero(input string tag);
      kbd.col_mask = 8'h00;
      for (int r = 0; r < 8; r++) begin
         kbd.row_sel = 3'(r);
         tick(2);
         check($sformatf("%s_row%0d", tag, r), int'(kbd.key_sense), 0);
      end
   endtask

   task automatic nmi_run(input string tag, input int rel_at, input int press2_at,
                          input int rel2_at, input int exp_rise);
      int fall;
      int rise;
      int saw_act;
      fall    = -1;
      rise    = -1;
      saw_act = 0;
      send_key(1'b1, 1'b0, 8'h07);
      for (int k = 0; k < 300; k++) begin
         @(posedge clk);
         #1;
         if (kbd.key_act) saw_act = 1;
         if (fall < 0 && !kbd.nmi_n) fall = k;
         if (fall >= 0 && rise < 0 && kbd.nmi_n) rise = k;
         if (k == rel_at)    send_key(1'b0, 1'b0, 8'h07);
         if (k == press2_at) send_key(1'b1, 1'b0, 8'h07);
         if (k == rel2_at)   send_key(1'b0, 1'b0, 8'h07);
      end
      check({tag, "_fall_cycle"}, fall, 3);
      check({tag, "_rise_cycle"}, rise, exp_rise);
      check({tag, "_no_key_act"}, saw_act, 0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      tog      = 1'b0;
      reset_n  = 1'b0;
      kbd.ps2_key  = 11'h000;
      kbd.row_sel  = 3'd0;
      kbd.col_mask = 8'hFF;

      //           press ext  code   row  mask   act   sense
      vecs[0]  = '{1'b1, 1'b0, 8'h1C, 3'd6, 8'hDF, 1'b1, 1'b1};  // A press
      vecs[1]  = '{1'b1, 1'b0, 8'h1C, 3'd6, 8'hDF, 1'b1, 1'b1};  // A again
      vecs[2]  = '{1'b1, 1'b0, 8'h1C, 3'd6, 8'hFF, 1'b1, 1'b0};  // no column selected
      vecs[3]  = '{1'b1, 1'b0, 8'h00, 3'd6, 8'hDF, 1'b0, 1'b1};  // unmapped, A still held
      vecs[4]  = '{1'b0, 1'b0, 8'h1C, 3'd6, 8'hDF, 1'b1, 1'b0};  // A release
      vecs[5]  = '{1'b0, 1'b0, 8'h1C, 3'd6, 8'hDF, 1'b1, 1'b0};  // release unheld
      vecs[6]  = '{1'b1, 1'b1, 8'h5A, 3'd7, 8'hDF, 1'b1, 1'b1};  // KP Enter
      vecs[7]  = '{1'b0, 1'b0, 8'h5A, 3'd7, 8'hDF, 1'b1, 1'b0};  // Return release
      vecs[8]  = '{1'b1, 1'b0, 8'h59, 3'd7, 8'hEF, 1'b1, 1'b1};  // R shift
      vecs[9]  = '{1'b1, 1'b0, 8'h12, 3'd4, 8'hEF, 1'b1, 1'b1};  // L shift
      vecs[10] = '{1'b0, 1'b0, 8'h59, 3'd7, 8'h00, 1'b1, 1'b0};  // R shift release
      vecs[11] = '{1'b0, 1'b0, 8'h12, 3'd4, 8'h00, 1'b1, 1'b0};  // L shift release
      vecs[12] = '{1'b1, 1'b0, 8'h29, 3'd0, 8'hFE, 1'b1, 1'b1};  // Space press
      vecs[13] = '{1'b0, 1'b0, 8'h29, 3'd0, 8'hFE, 1'b1, 1'b0};  // Space release
      vecs[14] = '{1'b1, 1'b1, 8'h07, 3'd0, 8'h00, 1'b0, 1'b0};  // E0 07 is not F12

      tick(3);
      check("reset_key_sense", int'(kbd.key_sense), 0);
      check("reset_nmi_n", int'(kbd.nmi_n), 1);
      check("reset_key_act", int'(kbd.key_act), 0);
      reset_n = 1'b1;
      tick(2);

      // Unmapped code 0x00: no key_act on any cycle, matrix stays empty.
      begin
         int acts;
         acts = 0;
         send_key(1'b1, 1'b0, 8'h00);
         for (int k = 0; k < 7; k++) begin
            tick(1);
            if (kbd.key_act) acts++;
         end
         check("unmapped_key_act", acts, 0);
         scan_all_zero("unmapped_scan");
      end

      for (int i = 0; i < 15; i++) begin
         kbd.row_sel  = vecs[i].row;
         kbd.col_mask = vecs[i].mask;
         send_key(vecs[i].press, vecs[i].ext, vecs[i].code);
         tick(3);
         check($sformatf("vec%0d_act_c2", i), int'(kbd.key_act), 0);
         tick(1);
         check($sformatf("vec%0d_act_c3", i), int'(kbd.key_act), int'(vecs[i].act));
         tick(1);
         check($sformatf("vec%0d_sense_c4", i), int'(kbd.key_sense), int'(vecs[i].sense));
      end

      // Back-to-back Space press and release.
      kbd.row_sel  = 3'd0;
      kbd.col_mask = 8'hFE;
      send_key(1'b1, 1'b0, 8'h29);
      tick(1);
      send_key(1'b0, 1'b0, 8'h29);
      tick(3);
      check("b2b_act_c3", int'(kbd.key_act), 1);
      tick(1);
      check("b2b_act_c4", int'(kbd.key_act), 1);
      check("b2b_sense_c4", int'(kbd.key_sense), 1);
      tick(1);
      check("b2b_act_c5", int'(kbd.key_act), 0);
      check("b2b_sense_c5", int'(kbd.key_sense), 0);
      tick(2);
      check("b2b_sense_end", int'(kbd.key_sense), 0);

      // key_sense follows a row_sel change one cycle later.
      kbd.row_sel  = 3'd6;
      kbd.col_mask = 8'hDF;
      send_key(1'b1, 1'b0, 8'h1C);
      tick(6);
      check("rowsel_before", int'(kbd.key_sense), 1);
      kbd.row_sel = 3'd0;
      #1;
      check("rowsel_same_cycle", int'(kbd.key_sense), 1);
      tick(1);
      check("rowsel_next_cycle", int'(kbd.key_sense), 0);
      send_key(1'b0, 1'b0, 8'h1C);
      tick(6);

      // NMI: short tap, long hold, and a re-press that reloads the counter.
      nmi_run("nmi_tap", 4, -1, -1, 67);
      nmi_run("nmi_hold", 199, -1, -1, 203);
      nmi_run("nmi_reload", 4, 29, 31, 97);

      // Hold A, L shift and F12, then pulse reset for one cycle.
      kbd.row_sel  = 3'd6;
      kbd.col_mask = 8'hDF;
      send_key(1'b1, 1'b0, 8'h1C);
      tick(1);
      send_key(1'b1, 1'b0, 8'h12);
      tick(1);
      send_key(1'b1, 1'b0, 8'h07);
      tick(1);
      // Leave the toggle low so nothing replays once reset releases.
      if (tog) send_key(1'b0, 1'b0, 8'h00);
      tick(8);
      check("pre_reset_sense", int'(kbd.key_sense), 1);
      check("pre_reset_nmi_n", int'(kbd.nmi_n), 0);
      reset_n = 1'b0;
      #1;
      check("async_reset_sense", int'(kbd.key_sense), 0);
      check("async_reset_nmi_n", int'(kbd.nmi_n), 1);
      tick(1);
      reset_n = 1'b1;
      scan_all_zero("post_reset_scan");
      check("post_reset_nmi_n", int'(kbd.nmi_n), 1);
      check("post_reset_key_act", int'(kbd.key_act), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
